// File: rtl/drop_scheduler.sv
// Gravity drop scheduler: turns timebase ticks into level-paced drop requests queued for the engine.
// Optional macro DROP_STATS_EN adds a drops_total counter of acknowledged drops.
module drop_scheduler #(
    parameter int LEVEL_W    = 4,
    parameter int PEND_W     = 3,
    parameter int BASE_TICKS = 20,
    parameter int STEP       = 2,
    parameter int MIN_TICKS  = 2,
    parameter int SOFT_TICKS = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick_in,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] level,
    input  logic               soft_drop,
    input  logic               clear,
    output logic               drop_req,
    input  logic               drop_ack,
    output logic [PEND_W-1:0]  pending,
    output logic               overrun,
    output logic [7:0]         period
`ifdef DROP_STATS_EN
    ,
    output logic [15:0]        drops_total
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic {
        OFF,
        COUNT
    } state_t;

    state_t              state;
    logic [7:0]          tcnt;
    logic signed [11:0]  lp_raw;
    logic [7:0]          lp;
    logic                counting;
    logic [8:0]          tcnt_inc;
    logic                drop_ev;
    logic                ack_v;
    logic                lost;
    logic [PEND_W-1:0]   pend_next;

    // Signed 12-bit arithmetic so a high level drives lp_raw negative instead of wrapping.
    assign lp_raw = 12'(BASE_TICKS) - 12'(level) * 12'(STEP);

    always_comb begin
        if (lp_raw < $signed(12'(MIN_TICKS)))
            lp = 8'(MIN_TICKS);
        else
            lp = lp_raw[7:0];
        if (soft_drop && (8'(SOFT_TICKS) < lp))
            period = 8'(SOFT_TICKS);
        else
            period = lp;
    end

    assign counting = (state == COUNT) && enable;
    assign tcnt_inc = {1'b0, tcnt} + 9'd1;
    // >= (not ==) so a period that shrinks below the running count fires on the next tick.
    assign drop_ev  = counting && tick_in && (tcnt_inc >= {1'b0, period});
    assign ack_v    = drop_ack && drop_req;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        pend_next = pending;
        lost      = 1'b0;
        if (drop_ev && !ack_v) begin
            if (pending == PEND_MAX)
                lost = 1'b1;
            else
                pend_next = pending + 1'b1;
        end else if (ack_v && !drop_ev) begin
            pend_next = pending - 1'b1;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= OFF;
            tcnt     <= '0;
            pending  <= '0;
            drop_req <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state <= enable ? COUNT : OFF;
            if (clear) begin
                tcnt     <= '0;
                pending  <= '0;
                drop_req <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                if (counting && tick_in)
                    tcnt <= drop_ev ? 8'd0 : tcnt_inc[7:0];
                pending  <= pend_next;
                drop_req <= (pend_next != '0);
                if (lost)
                    overrun <= 1'b1;
            end
        end
    end

`ifdef DROP_STATS_EN
    // Survives clear; only reset zeroes it. An ack discarded by clear is not counted.
    always_ff @(posedge clk) begin
        if (!reset_n)
            drops_total <= '0;
        else if (ack_v && !clear)
            drops_total <= drops_total + 16'd1;
    end
`endif

endmodule

// File: tb/tb_drop_scheduler.sv
// Self-checking bench for drop_scheduler: directed scenarios plus randomized traffic
// compared against a behavioural model of the drop queue.
module tb_drop_scheduler;

    localparam int LEVEL_W    = 4;
    localparam int PEND_W     = 3;
    localparam int BASE_TICKS = 20;
    localparam int STEP       = 2;
    localparam int MIN_TICKS  = 2;
    localparam int SOFT_TICKS = 1;
    localparam int MAX_PEND   = (1 << PEND_W) - 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               tick_in = 1'b0;
    logic               enable = 1'b0;
    logic [LEVEL_W-1:0] level = '0;
    logic               soft_drop = 1'b0;
    logic               clear = 1'b0;
    logic               drop_req;
    logic               drop_ack = 1'b0;
    logic [PEND_W-1:0]  pending;
    logic               overrun;
    logic [7:0]         period;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_tcnt = 0;
    int m_pend = 0;
    bit m_ovr  = 1'b0;
    bit m_req  = 1'b0;
    bit m_en_q = 1'b0;

    always #5 clk = ~clk;

    drop_scheduler #(
        .LEVEL_W(LEVEL_W), .PEND_W(PEND_W), .BASE_TICKS(BASE_TICKS),
        .STEP(STEP), .MIN_TICKS(MIN_TICKS), .SOFT_TICKS(SOFT_TICKS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .enable(enable),
        .level(level), .soft_drop(soft_drop), .clear(clear),
        .drop_req(drop_req), .drop_ack(drop_ack), .pending(pending),
        .overrun(overrun), .period(period)
    );

    function automatic int model_period(int lvl, bit sd);
        int lp;
        lp = BASE_TICKS - lvl * STEP;
        if (lp < MIN_TICKS) lp = MIN_TICKS;
        if (sd && SOFT_TICKS < lp) return SOFT_TICKS;
        return lp;
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge, then settle.
    task automatic cycle();
        bit ev, ackv;
        @(posedge clk);
        if (!reset_n) begin
            m_tcnt = 0; m_pend = 0; m_ovr = 0; m_req = 0; m_en_q = 0;
        end else begin
            if (clear) begin
                m_tcnt = 0; m_pend = 0; m_ovr = 0; m_req = 0;
            end else begin
                ev = 0;
                if (enable && m_en_q && tick_in) begin
                    if (m_tcnt + 1 >= model_period(int'(level), soft_drop)) begin
                        m_tcnt = 0;
                        ev = 1;
                    end else begin
                        m_tcnt++;
                    end
                end
                ackv = drop_ack && m_req;
                if (ev && !ackv) begin
                    if (m_pend == MAX_PEND) m_ovr = 1;
                    else m_pend++;
                end else if (ackv && !ev) begin
                    m_pend--;
                end
                m_req = (m_pend != 0);
            end
            m_en_q = enable;
        end
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic tick_once();
        tick_in = 1'b1;
        cycle();
        tick_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        level   = '0;
        tick_in = 1'b1;
        cycle();
        tick_in = 1'b0;
        cycle();
        tick_in = 1'b1;
        checks++;
        if (drop_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", drop_req); end
        checks++;
        if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++;
        if (period !== 8'd20) begin errors++; $display("FAIL reset_period: got %0d expected 20", period); end
        tick_in = 1'b0;
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_level0_drop();
        level = '0;
        for (int i = 1; i <= 20; i++) begin
            tick_once();
            if (i == 19) begin
                checks++;
                if (drop_req !== 1'b0) begin errors++; $display("FAIL lvl0_early_req: got %b expected 0", drop_req); end
            end
            if (i < 20) idle(2);
        end
        checks++;
        if (drop_req !== 1'b1) begin errors++; $display("FAIL lvl0_req: got %b expected 1", drop_req); end
        checks++;
        if (pending !== 3'd1) begin errors++; $display("FAIL lvl0_pending: got %0d expected 1", pending); end
        idle(2);
        drop_ack = 1'b1;
        cycle();
        drop_ack = 1'b0;
        checks++;
        if (pending !== 3'd0 || drop_req !== 1'b0) begin
            errors++; $display("FAIL lvl0_ack: got pending=%0d req=%b expected 0/0", pending, drop_req);
        end
        // An ack with nothing pending must not underflow.
        drop_ack = 1'b1;
        cycle();
        drop_ack = 1'b0;
        checks++;
        if (pending !== 3'd0) begin errors++; $display("FAIL ack_underflow: got %0d expected 0", pending); end
    endtask

    task automatic test_saturate_clear();
        pulse_clear();
        level = 4'd12;
        #1;
        checks++;
        if (period !== 8'd2) begin errors++; $display("FAIL clamp_period: got %0d expected 2", period); end
        for (int i = 1; i <= 16; i++) begin
            tick_once();
            if (i == 14) begin
                checks++;
                if (pending !== 3'd7 || overrun !== 1'b0) begin
                    errors++; $display("FAIL sat_14: got pending=%0d ovr=%b expected 7/0", pending, overrun);
                end
            end
            idle(1);
        end
        checks++;
        if (pending !== 3'd7 || overrun !== 1'b1) begin
            errors++; $display("FAIL sat_16: got pending=%0d ovr=%b expected 7/1", pending, overrun);
        end
        // Clear wins over a tick and an ack in the same cycle.
        tick_in  = 1'b1;
        drop_ack = 1'b1;
        pulse_clear();
        tick_in  = 1'b0;
        drop_ack = 1'b0;
        checks++;
        if (pending !== 3'd0 || overrun !== 1'b0 || drop_req !== 1'b0) begin
            errors++; $display("FAIL clear: got pending=%0d ovr=%b req=%b expected 0/0/0", pending, overrun, drop_req);
        end
    endtask

    task automatic test_ack_and_event();
        level = 4'd12;
        tick_once(); idle(1);
        tick_once(); idle(1);
        tick_once(); idle(1);
        drop_ack = 1'b1;
        tick_once();
        drop_ack = 1'b0;
        checks++;
        if (pending !== 3'd1 || drop_req !== 1'b1) begin
            errors++; $display("FAIL ack_and_event: got pending=%0d req=%b expected 1/1", pending, drop_req);
        end
    endtask

    task automatic test_soft_drop();
        pulse_clear();
        level = '0;
        repeat (7) begin tick_once(); idle(1); end
        soft_drop = 1'b1;
        #1;
        checks++;
        if (period !== 8'd1) begin errors++; $display("FAIL soft_period: got %0d expected 1", period); end
        tick_once();
        checks++;
        if (pending !== 3'd1 || drop_req !== 1'b1) begin
            errors++; $display("FAIL soft_event: got pending=%0d req=%b expected 1/1", pending, drop_req);
        end
        soft_drop = 1'b0;
        idle(1);
    endtask

    task automatic test_enable_hold();
        pulse_clear();
        level = 4'd12;
        repeat (4) begin tick_once(); idle(1); end
        level = '0;
        repeat (5) begin tick_once(); idle(2); end
        enable = 1'b0;
        idle(2);
        repeat (10) begin tick_once(); idle(2); end
        checks++;
        if (pending !== 3'd2) begin errors++; $display("FAIL off_ticks: got pending=%0d expected 2", pending); end
        drop_ack = 1'b1;
        cycle();
        drop_ack = 1'b0;
        checks++;
        if (pending !== 3'd1) begin errors++; $display("FAIL off_ack: got pending=%0d expected 1", pending); end
        enable = 1'b1;
        idle(2);
        for (int i = 1; i <= 15; i++) begin
            tick_once();
            if (i == 14) begin
                checks++;
                if (pending !== 3'd1) begin errors++; $display("FAIL resume_14: got pending=%0d expected 1", pending); end
            end
            idle(2);
        end
        checks++;
        if (pending !== 3'd2) begin errors++; $display("FAIL resume_15: got pending=%0d expected 2", pending); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 299) != 0);
            clear     = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) level = LEVEL_W'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) soft_drop = ~soft_drop;
            tick_in   = ($urandom_range(0, 2) == 0);
            drop_ack  = ($urandom_range(0, 4) == 0);
            cycle();
            checks++;
            if (drop_req !== m_req) begin errors++; $display("FAIL rnd_req @%0d: got %b expected %b", i, drop_req, m_req); end
            checks++;
            if (pending !== PEND_W'(m_pend)) begin errors++; $display("FAIL rnd_pending @%0d: got %0d expected %0d", i, pending, m_pend); end
            checks++;
            if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun @%0d: got %b expected %b", i, overrun, m_ovr); end
            checks++;
            if (period !== 8'(model_period(int'(level), soft_drop))) begin
                errors++; $display("FAIL rnd_period @%0d: got %0d expected %0d", i, period, model_period(int'(level), soft_drop));
            end
        end
        reset_n  = 1'b1;
        clear    = 1'b0;
        tick_in  = 1'b0;
        drop_ack = 1'b0;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_level0_drop();
        test_saturate_clear();
        test_ack_and_event();
        test_soft_drop();
        test_enable_hold();
        enable = 1'b1;
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
